// File: rtl/instr_sequencer.sv
// Instruction sequencer: feeds the core's iin/Run from a writable program memory, then waits for Done.
// Optional macro SEQ_WRAP_EN: on Done at the last address, pc wraps to 0 instead of halting.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF,
  parameter int                TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] iin,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       issued,
  output logic              halted,
  output logic              error
);
  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam int                TW         = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PC_LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_iin;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_issued;
  logic              r_error;
  logic [TW-1:0]     r_timer;

  logic              w_loadable;
  logic              w_last;
  logic              w_timeout;
  logic [DATA_W-1:0] w_fetch_word;

  assign w_loadable   = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_last       = (r_pc == PC_LAST);
  assign w_fetch_word = r_mem[r_pc];
  // r_timer counts cycles since the run pulse; the last permitted Done cycle is TIMEOUT-1.
  assign w_timeout    = (r_state == S_WAIT) && !done && (r_timer == TIMER_LAST);

  // NOTE: program memory has no reset branch; its contents must survive reset and need no flops' reset tree.
  always_ff @(posedge clock) begin
    if (prog_we && w_loadable) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start) w_state_next = S_FETCH;
      S_FETCH:        w_state_next = (w_fetch_word == HALT_WORD) ? S_HALT : S_ISSUE;
      S_ISSUE:        w_state_next = S_WAIT;
      S_WAIT: begin
        if (done) begin
`ifdef SEQ_WRAP_EN
          w_state_next = S_FETCH;
`else
          w_state_next = w_last ? S_HALT : S_FETCH;
`endif
        end else if (w_timeout) begin
          w_state_next = S_HALT;
        end
      end
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iin    <= '0;
      r_pc     <= '0;
      r_issued <= '0;
      r_error  <= 1'b0;
      r_timer  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc     <= '0;
            r_issued <= '0;
            r_error  <= 1'b0;
          end
        end
        S_FETCH: r_iin   <= w_fetch_word;
        S_ISSUE: r_timer <= TW'(1);
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (done) begin
            if (r_issued != 16'hFFFF) r_issued <= r_issued + 16'd1;
`ifdef SEQ_WRAP_EN
            r_pc <= w_last ? '0 : r_pc + 1'b1;
`else
            if (!w_last) r_pc <= r_pc + 1'b1;
`endif
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // run and halted decode the state register, so reset clears them without waiting for a clock.
  assign run    = (r_state == S_ISSUE);
  assign halted = (r_state == S_HALT);
  assign iin    = r_iin;
  assign pc     = r_pc;
  assign issued = r_issued;
  assign error  = r_error;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven programs plus hand-written corner sequences.
// Issued instructions are checked by a scoreboard popped on every run pulse.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int TIMEOUT = 64;

  logic        clock, reset, start, done, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] iin;
  logic        run;
  logic [3:0]  pc;
  logic [15:0] issued;
  logic        halted, error;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] sb_exp;

  typedef struct packed {
    logic [3:0][15:0] w;
    int               dly;
    int               exp_issued;
    int               exp_pc;
    bit               exp_error;
  } vec_t;

  vec_t vecs [6];

  instr_sequencer #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .HALT_WORD(16'hFFFF),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .iin      (iin),
    .run      (run),
    .pc       (pc),
    .issued   (issued),
    .halted   (halted),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (run === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_run: iin %h issued with nothing expected", iin);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_iin", {16'h0, iin}, {16'h0, sb_exp});
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3,
                              input int dly, input int iss, input int pcv, input bit err);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.dly = dly; v.exp_issued = iss; v.exp_pc = pcv; v.exp_error = err;
    return v;
  endfunction

  task automatic load_word(input int a, input logic [15:0] d);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d;
  endtask

  task automatic wait_run(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      k++;
    end while (run !== 1'b1 && k < 200);
    check({tag, "_run_seen"}, {31'h0, run}, 1);
  endtask

  task automatic wait_halt(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (halted !== 1'b1 && k < 400);
    check({tag, "_halt_seen"}, {31'h0, halted}, 1);
  endtask

  // Loads words 0..3 from the vector (rest HALT), runs it with Done dly cycles after each run.
  task automatic run_vec(input vec_t v, input string tag);
    int  cyc, since_run, last_done, nrun;
    bit  seen_halt;
    for (int a = 0; a < 16; a++) load_word(a, (a < 4) ? v.w[a] : 16'hFFFF);
    @(negedge clock);
    prog_we = 1'b0;
    for (int k = 0; k < v.exp_issued + int'(v.exp_error); k++) sb_q.push_back(v.w[k]);
    start = 1'b1;
    cyc = 0; since_run = -1; last_done = -1; nrun = 0; seen_halt = 1'b0;
    while (cyc < 2000 && !seen_halt) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      done  = 1'b0;
      if (run === 1'b1) begin
        if (nrun == 0) check({tag, "_start2run"}, cyc, 2);
        else           check({tag, "_done2run"}, cyc - last_done, 2);
        nrun++;
        since_run = 0;
      end else if (since_run >= 0) begin
        since_run++;
      end
      if (halted === 1'b1) begin
        seen_halt = 1'b1;
        if (v.exp_error)            check({tag, "_timeout_lat"}, since_run, TIMEOUT);
        else if (v.exp_issued == 0) check({tag, "_halt_lat"}, cyc, 2);
      end else if (v.dly > 0 && since_run == v.dly) begin
        check({tag, "_iin_hold"}, {16'h0, iin}, {16'h0, v.w[nrun-1]});
        done      = 1'b1;
        last_done = cyc;
        since_run = -1;
      end
    end
    done = 1'b0;
    check({tag, "_halted"}, {31'h0, halted}, 1);
    check({tag, "_issued"}, {16'h0, issued}, v.exp_issued);
    check({tag, "_pc"}, {28'h0, pc}, v.exp_pc);
    check({tag, "_error"}, {31'h0, error}, {31'h0, v.exp_error});
    check({tag, "_sb_drain"}, sb_q.size(), 0);
  endtask

  initial begin
    int n3;
    vecs[0] = mk(16'hA01C, 16'hA40A, 16'h8000, 16'hFFFF, 4,           3, 3, 1'b0);
    vecs[1] = mk(16'hA01C, 16'hA40A, 16'h8000, 16'hFFFF, -1,          0, 0, 1'b1);
    vecs[2] = mk(16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 1,           0, 0, 1'b0);
    vecs[3] = mk(16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 1,           1, 1, 1'b0);
    vecs[4] = mk(16'h0000, 16'hFFFE, 16'hFFFF, 16'hFFFF, TIMEOUT - 1, 2, 2, 1'b0);
    vecs[5] = mk(16'h5555, 16'hFFFF, 16'hFFFF, 16'hFFFF, TIMEOUT,     0, 0, 1'b1);

    reset = 1'b1; start = 1'b0; done = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(negedge clock);
    check("rst_run", {31'h0, run}, 0);
    check("rst_iin", {16'h0, iin}, 0);
    check("rst_pc", {28'h0, pc}, 0);
    check("rst_issued", {16'h0, issued}, 0);
    check("rst_halted", {31'h0, halted}, 0);
    check("rst_error", {31'h0, error}, 0);
    reset = 1'b0;

    // Done in IDLE and in ISSUE is ignored; a program write during WAIT is dropped.
    for (int a = 0; a < 16; a++) load_word(a, (a == 0) ? 16'hA01C : (a == 1) ? 16'hA40A : 16'hFFFF);
    @(negedge clock);
    prog_we = 1'b0;
    done    = 1'b1;
    @(negedge clock);
    done = 1'b0;
    check("t4_idle_pc", {28'h0, pc}, 0);
    check("t4_idle_halted", {31'h0, halted}, 0);
    check("t4_idle_run", {31'h0, run}, 0);
    sb_q.push_back(16'hA01C);
    sb_q.push_back(16'hA40A);
    start = 1'b1;
    wait_run("t4_run0");
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    check("t4_issue_done_issued", {16'h0, issued}, 0);
    check("t4_issue_done_pc", {28'h0, pc}, 0);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hDEAD;
    @(negedge clock);
    prog_we = 1'b0;
    check("t4_wait_pc", {28'h0, pc}, 0);
    repeat (2) @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    wait_run("t4_run1");
    @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    wait_halt("t4");
    check("t4_issued", {16'h0, issued}, 2);
    check("t4_pc", {28'h0, pc}, 2);
    check("t4_error", {31'h0, error}, 0);
    check("t4_sb_drain", sb_q.size(), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Full memory of non-halt words: end-of-memory behaviour.
    for (int a = 0; a < 16; a++) load_word(a, 16'h8000);
    @(negedge clock);
    prog_we = 1'b0;
`ifdef SEQ_WRAP_EN
    n3 = 20;
`else
    n3 = 16;
`endif
    for (int k = 0; k < n3; k++) sb_q.push_back(16'h8000);
    start = 1'b1;
    for (int k = 0; k < n3; k++) begin
      wait_run("t3");
      @(negedge clock);
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
    end
`ifdef SEQ_WRAP_EN
    check("t3_halted", {31'h0, halted}, 0);
    check("t3_issued", {16'h0, issued}, 20);
    check("t3_pc", {28'h0, pc}, 4);
`else
    check("t3_halted", {31'h0, halted}, 1);
    check("t3_issued", {16'h0, issued}, 16);
    check("t3_pc", {28'h0, pc}, 15);
`endif
    check("t3_error", {31'h0, error}, 0);
    check("t3_sb_drain", sb_q.size(), 0);
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Reset during WAIT of the second instruction, then restart from word 0.
    for (int a = 0; a < 16; a++)
      load_word(a, (a == 0) ? 16'hA01C : (a == 1) ? 16'hA40A : (a == 2) ? 16'h8000 : 16'hFFFF);
    @(negedge clock);
    prog_we = 1'b0;
    sb_q.push_back(16'hA01C);
    sb_q.push_back(16'hA40A);
    start = 1'b1;
    wait_run("t5_run0");
    repeat (2) @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    wait_run("t5_run1");
    @(negedge clock);
    check("t5_pre_pc", {28'h0, pc}, 1);
    check("t5_pre_issued", {16'h0, issued}, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_run", {31'h0, run}, 0);
    check("t5_rst_iin", {16'h0, iin}, 0);
    check("t5_rst_pc", {28'h0, pc}, 0);
    check("t5_rst_issued", {16'h0, issued}, 0);
    check("t5_rst_halted", {31'h0, halted}, 0);
    @(negedge clock);
    reset = 1'b0;
    sb_q.push_back(16'hA01C);
    start = 1'b1;
    wait_run("t5_restart");
    @(negedge clock);
    check("t5_restart_pc", {28'h0, pc}, 0);
    check("t5_sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
